// File: rtl/axis_pattern_source.sv
// AXI-Stream master emitting a programmable run of patterned beats with TLAST framing
// and optional idle gaps between accepted beats.
module axis_pattern_source #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    CNT_WIDTH  = 16,
    parameter int                    PKT_LEN    = 16,
    parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = 8'hB8,
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = 8'h01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic [3:0]            gap,
    input  logic [DATA_WIDTH-1:0] const_val,
    output logic                  busy,
    output logic                  done,
    output logic                  M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY
);

    localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PW-1:0]        PKT_END = PW'(PKT_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                state;
    logic [1:0]            mode_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [3:0]            gap_r;
    logic [DATA_WIDTH-1:0] const_r;
    logic [CNT_WIDTH-1:0]  beat;
    logic [PW-1:0]         pkt;
    logic [3:0]            gap_cnt;

    logic                  hs;
    logic                  last_beat;
    logic [CNT_WIDTH-1:0]  beat_nxt;
    logic [PW-1:0]         pkt_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [DATA_WIDTH-1:0] data_init;

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    assign hs        = M_AXIS_TVALID && M_AXIS_TREADY;
    assign last_beat = (beat == cnt_r - CNT_ONE);
    assign beat_nxt  = beat + CNT_ONE;
    assign pkt_nxt   = (pkt == PKT_END) ? '0 : pkt + PW'(1);

    always_comb begin
        data_nxt = M_AXIS_TDATA;
        case (mode_r)
            2'd0:    data_nxt = M_AXIS_TDATA + DATA_WIDTH'(1);
            2'd1:    data_nxt = M_AXIS_TDATA - DATA_WIDTH'(1);
            2'd2:    data_nxt = lfsr_step(M_AXIS_TDATA);
            default: data_nxt = const_r;
        endcase
    end

    always_comb begin
        data_init = '0;
        case (mode)
            2'd0:    data_init = '0;
            2'd1:    data_init = '1;
            2'd2:    data_init = LFSR_SEED;
            default: data_init = const_val;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mode_r        <= '0;
            cnt_r         <= '0;
            gap_r         <= '0;
            const_r       <= '0;
            beat          <= '0;
            pkt           <= '0;
            gap_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r  <= mode;
                        cnt_r   <= count;
                        gap_r   <= gap;
                        const_r <= const_val;
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state         <= SEND;
                            busy          <= 1'b1;
                            beat          <= '0;
                            pkt           <= '0;
                            M_AXIS_TVALID <= 1'b1;
                            M_AXIS_TDATA  <= data_init;
                            M_AXIS_TLAST  <= (PKT_LEN == 1) || (count == CNT_ONE);
                        end
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (last_beat) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            M_AXIS_TVALID <= 1'b0;
                            M_AXIS_TLAST  <= 1'b0;
                        end else begin
                            // Next beat is staged now so TDATA is ready the moment a gap ends.
                            beat         <= beat_nxt;
                            pkt          <= pkt_nxt;
                            M_AXIS_TDATA <= data_nxt;
                            M_AXIS_TLAST <= (pkt_nxt == PKT_END) || (beat_nxt == cnt_r - CNT_ONE);
                            if (gap_r != '0) begin
                                state         <= GAP;
                                gap_cnt       <= gap_r;
                                M_AXIS_TVALID <= 1'b0;
                            end
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt == 4'd1) begin
                        state         <= SEND;
                        M_AXIS_TVALID <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_source.sv
// Directed bench for axis_pattern_source: patterns, framing, backpressure, gaps, reset.
module tb_axis_pattern_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] count;
    logic [3:0]  gap;
    logic [7:0]  const_val;
    logic        busy, done;
    logic        tvalid, tlast, tready;
    logic [7:0]  tdata;

    int checks = 0;
    int errors = 0;

    axis_pattern_source dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .count(count), .gap(gap),
        .const_val(const_val), .busy(busy), .done(done),
        .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast),
        .M_AXIS_TREADY(tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic l);
        chk({tag, " valid"}, {31'd0, tvalid}, 32'd1);
        chk({tag, " data"}, {24'd0, tdata}, {24'd0, d});
        chk({tag, " last"}, {31'd0, tlast}, {31'd0, l});
    endtask

    task automatic launch(input logic [1:0] m, input logic [15:0] c, input logic [3:0] g,
                          input logic [7:0] cv);
        mode = m; count = c; gap = g; const_val = cv; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic end_of_run(input string tag);
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " idle valid"}, {31'd0, tvalid}, 32'd0);
        chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
        tick;
        chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; count = '0; gap = '0; const_val = '0;
        tready = 1'b1;
        #12;
        chk("reset valid", {31'd0, tvalid}, 32'd0);
        chk("reset data", {24'd0, tdata}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick;

        // Mode 0, four back-to-back beats
        launch(2'd0, 16'd4, 4'd0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            beat("t1", 8'(i), i == 3);
            chk("t1 busy", {31'd0, busy}, 32'd1);
            tick;
        end
        chk("t1 last cleared", {31'd0, tlast}, 32'd0);
        end_of_run("t1");

        // Packet framing and 8-bit wrap over 258 beats
        launch(2'd0, 16'd258, 4'd0, 8'h00);
        for (int i = 0; i < 258; i++) begin
            beat("t2", 8'(i), ((i + 1) % 16 == 0) || (i == 257));
            tick;
        end
        end_of_run("t2");

        // Backpressure held on beat 2
        launch(2'd0, 16'd5, 4'd0, 8'h00);
        beat("t3 b0", 8'h00, 1'b0); tick;
        beat("t3 b1", 8'h01, 1'b0);
        tick;
        tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat("t3 stall", 8'h02, 1'b0);
            tick;
        end
        beat("t3 b2", 8'h02, 1'b0);
        tready = 1'b1;
        tick;
        beat("t3 b3", 8'h03, 1'b0); tick;
        beat("t3 b4", 8'h04, 1'b1); tick;
        end_of_run("t3");

        // Mode 1 with two-cycle gaps
        launch(2'd1, 16'd3, 4'd2, 8'h00);
        beat("t4 b0", 8'hFF, 1'b0); tick;
        chk("t4 gap0a", {31'd0, tvalid}, 32'd0); tick;
        chk("t4 gap0b", {31'd0, tvalid}, 32'd0); tick;
        beat("t4 b1", 8'hFE, 1'b0); tick;
        chk("t4 gap1a", {31'd0, tvalid}, 32'd0); tick;
        chk("t4 gap1b", {31'd0, tvalid}, 32'd0); tick;
        beat("t4 b2", 8'hFD, 1'b1); tick;
        end_of_run("t4");

        // LFSR: seed first, then Galois steps 01 -> B8 -> 5C -> 2E
        launch(2'd2, 16'd4, 4'd0, 8'h00);
        beat("t5 l0", 8'h01, 1'b0); tick;
        beat("t5 l1", 8'hB8, 1'b0); tick;
        beat("t5 l2", 8'h5C, 1'b0); tick;
        beat("t5 l3", 8'h2E, 1'b1); tick;
        end_of_run("t5l");

        // Constant, with start sampled in the done cycle of the previous run
        launch(2'd3, 16'd3, 4'd0, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            beat("t5 const", 8'hA5, i == 2);
            tick;
        end
        chk("t5 done", {31'd0, done}, 32'd1);
        launch(2'd0, 16'd2, 4'd0, 8'h00);
        beat("b2b b0", 8'h00, 1'b0); tick;
        beat("b2b b1", 8'h01, 1'b1); tick;
        end_of_run("b2b");

        // Zero-length run
        launch(2'd0, 16'd0, 4'd0, 8'h00);
        chk("t6 zero valid", {31'd0, tvalid}, 32'd0);
        end_of_run("t6 zero");

        // start while busy is ignored
        launch(2'd0, 16'd3, 4'd0, 8'h00);
        mode = 2'd3; count = 16'd10; const_val = 8'h5A; start = 1'b1;
        beat("t6 ign b0", 8'h00, 1'b0); tick;
        start = 1'b0;
        beat("t6 ign b1", 8'h01, 1'b0); tick;
        beat("t6 ign b2", 8'h02, 1'b1); tick;
        end_of_run("t6 ign");

        // Reset mid-run
        launch(2'd0, 16'd10, 4'd0, 8'h00);
        tick; tick;
        rst = 1'b1;
        #1;
        chk("t6 rst valid", {31'd0, tvalid}, 32'd0);
        chk("t6 rst data", {24'd0, tdata}, 32'd0);
        chk("t6 rst busy", {31'd0, busy}, 32'd0);
        chk("t6 rst last", {31'd0, tlast}, 32'd0);
        tick;
        rst = 1'b0;
        tick;
        chk("t6 rst no done", {31'd0, done}, 32'd0);
        launch(2'd0, 16'd2, 4'd0, 8'h00);
        beat("t6 after b0", 8'h00, 1'b0); tick;
        beat("t6 after b1", 8'h01, 1'b1); tick;
        end_of_run("t6 after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
